// File: rtl/m3_six_step_commutator.sv
// m3_six_step_commutator: six-step 3-phase gate sequencer with dead time and per-round pulse.
// One counter spans the whole step (dead time included); DEAD ends once DEAD_CYC counts have elapsed.
module m3_six_step_commutator #(
    parameter int PERIOD_W   = 32,
    parameter int DEAD_CYC   = 8,
    parameter int PERIOD_MIN = 40
) (
    input  logic                clkI,
    input  logic                rstI,
    input  logic                workingI,
    input  logic                forceStopI,
    input  logic                invRotateI,
    input  logic [PERIOD_W-1:0] roundLenI,
    output logic [2:0]          phaseHiO,
    output logic [2:0]          phaseLoO,
    output logic [2:0]          stepO,
    output logic                nextRoundO,
    output logic                runningO
);
    typedef enum logic [1:0] {IDLE, DEAD, DRIVE, STOP} state_t;
    localparam int FLOOR_I = PERIOD_MIN > 2*DEAD_CYC ? PERIOD_MIN : 2*DEAD_CYC;
    localparam logic [PERIOD_W-1:0] FLOOR  = PERIOD_W'(FLOOR_I);
    localparam logic [PERIOD_W-1:0] DEAD_W = PERIOD_W'(DEAD_CYC);
    localparam logic [PERIOD_W-1:0] ONE    = PERIOD_W'(1);
    state_t r_state, w_nxt;
    logic [PERIOD_W-1:0] r_cnt, r_len, w_len, w_cnt_nxt, w_len_nxt;
    logic [2:0] r_round, w_round_nxt, w_step_nxt, w_hi, w_lo;
    logic w_wrap;
    assign w_len = roundLenI > FLOOR ? roundLenI : FLOOR;
    always_comb begin
        w_nxt       = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_step_nxt  = stepO;
        w_round_nxt = r_round;
        w_wrap      = 1'b0;
        if (forceStopI || !workingI || r_state == STOP) begin
            w_nxt       = forceStopI ? STOP : IDLE;
            w_cnt_nxt   = '0;
            w_step_nxt  = 3'd0;
            w_round_nxt = 3'd0;
        end else if (r_state == IDLE || r_cnt == '0) begin
            // Step boundary: new length is sampled here and only here
            w_nxt     = DEAD;
            w_len_nxt = w_len;
            w_cnt_nxt = w_len - ONE;
            if (r_state != IDLE) begin
                w_step_nxt  = invRotateI ? (stepO == 3'd0 ? 3'd5 : stepO - 3'd1)
                                         : (stepO == 3'd5 ? 3'd0 : stepO + 3'd1);
                w_round_nxt = r_round == 3'd5 ? 3'd0 : r_round + 3'd1;
                w_wrap      = r_round == 3'd5;
            end
        end else begin
            w_cnt_nxt = r_cnt - ONE;
            if (r_state == DEAD && r_cnt == r_len - DEAD_W) w_nxt = DRIVE;
        end
    end
    assign w_hi = w_step_nxt < 3'd2 ? 3'b001 : w_step_nxt < 3'd4 ? 3'b010 : 3'b100;
    assign w_lo = (w_step_nxt == 3'd1 || w_step_nxt == 3'd2) ? 3'b100 :
                  (w_step_nxt == 3'd3 || w_step_nxt == 3'd4) ? 3'b001 : 3'b010;
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_round    <= 3'd0;
            stepO      <= 3'd0;
            phaseHiO   <= 3'b000;
            phaseLoO   <= 3'b000;
            nextRoundO <= 1'b0;
            runningO   <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_round    <= w_round_nxt;
            stepO      <= w_step_nxt;
            phaseHiO   <= w_nxt == DRIVE ? w_hi : 3'b000;
            phaseLoO   <= w_nxt == DRIVE ? w_lo : 3'b000;
            nextRoundO <= w_wrap;
            runningO   <= w_nxt == DEAD || w_nxt == DRIVE;
        end
    end
endmodule
